// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - issue-stage register/mul-div scoreboard
// Per-register countdown of cycles until an in-flight write is readable; drives issue stall.
module hazard_scoreboard #(
    parameter int NREG       = 32,
    parameter int CW         = 3,
    parameter int MD_OCC     = 4,
    parameter int FLUSH_KEEP = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic [4:0]    issue_rs1,
    input  logic [4:0]    issue_rs2,
    input  logic          issue_use_rs1,
    input  logic          issue_use_rs2,
    input  logic [4:0]    issue_rd,
    input  logic          issue_we,
    input  logic [CW-1:0] issue_lat,
    input  logic          issue_muldiv,
    input  logic          flush,
    output logic          stall,
    output logic [CW-1:0] stall_cycles,
    output logic [5:0]    busy_regs
);

    logic [CW-1:0] cnt [NREG];
    logic [CW-1:0] md_cnt;

    logic [CW-1:0] cnt_rs1, cnt_rs2, cnt_rd, waw_need, max_need;
    logic          raw1, raw2, waw, struct_haz, accept;

    assign cnt_rs1 = cnt[issue_rs1];
    assign cnt_rs2 = cnt[issue_rs2];
    assign cnt_rd  = cnt[issue_rd];

    assign raw1       = issue_valid & issue_use_rs1 & (cnt_rs1 != '0);
    assign raw2       = issue_valid & issue_use_rs2 & (cnt_rs2 != '0);
    assign waw        = issue_valid & issue_we & (issue_rd != 5'd0) & (cnt_rd >= issue_lat);
    assign struct_haz = issue_valid & issue_muldiv & (md_cnt != '0);
    // cnt_rd >= issue_lat whenever waw is set, so this never wraps where it is used
    assign waw_need   = cnt_rd - issue_lat + CW'(1);

    assign stall  = issue_valid & ~flush & (raw1 | raw2 | waw | struct_haz);
    assign accept = issue_valid & ~stall & ~flush;

    always_comb begin
        max_need = '0;
        if (raw1 && cnt_rs1 > max_need) max_need = cnt_rs1;
        if (raw2 && cnt_rs2 > max_need) max_need = cnt_rs2;
        if (waw && waw_need > max_need) max_need = waw_need;
        if (struct_haz && md_cnt > max_need) max_need = md_cnt;
    end

    assign stall_cycles = stall ? max_need : '0;

    always_comb begin
        busy_regs = '0;
        for (int r = 1; r < NREG; r++) begin
            busy_regs = busy_regs + {5'd0, (cnt[r] != '0)};
        end
    end

    always_ff @(posedge clk) begin
        cnt[0] <= '0;
        if (rst) begin
            for (int r = 1; r < NREG; r++) cnt[r] <= '0;
            md_cnt <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (flush && cnt[r] > CW'(FLUSH_KEEP))
                    cnt[r] <= '0;
                else if (accept && issue_we && issue_rd == r[4:0])
                    cnt[r] <= issue_lat;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - CW'(1);
            end
            if (flush)
                md_cnt <= '0;
            else if (accept && issue_muldiv)
                md_cnt <= CW'(MD_OCC);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - CW'(1);
        end
    end

endmodule
